interp_sweep_checker: RTL and testbench

Downstream verification/characterisation stage for the LUT interpolation core. It sweeps the 8-bit x input across a programmable range and holds each point long enough for the core's registered ROM outputs to settle. At each point it samples the linear, quadratic and exact results and accumulates absolute-error statistics. The statistics are per-sweep sum and maximum error for each interpolator, plus the x at which each maximum occurs. It sits directly after the interpolation core, drives its x_input and consumes its three y outputs.

---
 rtl/interp_sweep_checker_pkg.sv | 8 +
 rtl/interp_sweep_checker_abs_diff8.sv | 10 +
 rtl/interp_sweep_checker.sv | 126 ++++++++++++
 tb/tb_interp_sweep_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/interp_sweep_checker_pkg.sv
// interp_sweep_checker_pkg: shared FSM encoding, widths and default sweep range.
package interp_sweep_checker_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_e;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int X_START_DEF = 0;
  localparam int X_END_DEF = 255;
endpackage

// File: rtl/interp_sweep_checker_abs_diff8.sv
// abs_diff8: combinational unsigned 8-bit absolute difference |a-b|.
module abs_diff8
  import interp_sweep_checker_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  assign y = (a > b) ? a - b : b - a;
endmodule

// File: rtl/interp_sweep_checker.sv
// interp_sweep_checker: sweeps x over [X_START, X_END] and accumulates |lin-exact| and |quad-exact| statistics.
module interp_sweep_checker
  import interp_sweep_checker_pkg::*;
#(
  parameter int X_START = X_START_DEF,
  parameter int X_END = X_END_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [DW-1:0] x_out,
  input  logic [DW-1:0] y_linear,
  input  logic [DW-1:0] y_quadratic,
  input  logic [DW-1:0] y_exact,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sum_err_lin,
  output logic [AW-1:0] sum_err_quad,
  output logic [DW-1:0] max_err_lin,
  output logic [DW-1:0] max_err_quad,
  output logic [DW-1:0] argmax_lin,
  output logic [DW-1:0] argmax_quad
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DW-1:0] XS = DW'(X_START);
  localparam logic [DW-1:0] XE = DW'(X_END);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] x_q, x_d, max_lin_q, max_lin_d, max_quad_q, max_quad_d;
  logic [DW-1:0] arg_lin_q, arg_lin_d, arg_quad_q, arg_quad_d, e_l, e_q;
  logic [AW-1:0] sum_lin_q, sum_lin_d, sum_quad_q, sum_quad_d;
  logic busy_q, busy_d, done_q, done_d;
  abs_diff8 u_abs_lin (.a(y_linear), .b(y_exact), .y(e_l));
  abs_diff8 u_abs_quad (.a(y_quadratic), .b(y_exact), .y(e_q));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    busy_d = busy_q;
    done_d = 1'b0;
    sum_lin_d = sum_lin_q;
    sum_quad_d = sum_quad_q;
    max_lin_d = max_lin_q;
    max_quad_d = max_quad_q;
    arg_lin_d = arg_lin_q;
    arg_quad_d = arg_quad_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        cnt_d = '0;
        x_d = XS;
        busy_d = 1'b1;
        sum_lin_d = '0;
        sum_quad_d = '0;
        max_lin_d = '0;
        max_quad_d = '0;
        arg_lin_d = '0;
        arg_quad_d = '0;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        sum_lin_d = sum_lin_q + {{(AW-DW){1'b0}}, e_l};
        sum_quad_d = sum_quad_q + {{(AW-DW){1'b0}}, e_q};
        // strict compare so ties keep the earliest x
        if (e_l > max_lin_q) begin
          max_lin_d = e_l;
          arg_lin_d = x_q;
        end
        if (e_q > max_quad_q) begin
          max_quad_d = e_q;
          arg_quad_d = x_q;
        end
        cnt_d = '0;
        if (x_q == XE) begin
          state_d = FINISH;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = SETTLE;
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= XS;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_lin_q <= '0;
      sum_quad_q <= '0;
      max_lin_q <= '0;
      max_quad_q <= '0;
      arg_lin_q <= '0;
      arg_quad_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sum_lin_q <= sum_lin_d;
      sum_quad_q <= sum_quad_d;
      max_lin_q <= max_lin_d;
      max_quad_q <= max_quad_d;
      arg_lin_q <= arg_lin_d;
      arg_quad_q <= arg_quad_d;
    end
  end
  assign x_out = x_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sum_err_lin = sum_lin_q;
  assign sum_err_quad = sum_quad_q;
  assign max_err_lin = max_lin_q;
  assign max_err_quad = max_quad_q;
  assign argmax_lin = arg_lin_q;
  assign argmax_quad = arg_quad_q;
endmodule

// File: tb/tb_interp_sweep_checker.sv
// tb_interp_sweep_checker: directed tests against a registered behavioural interpolation core model.
module tb_interp_sweep_checker;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
  logic [7:0] x0, yl0, yq0, ye0, ml0, mq0, al0, aq0;
  logic [7:0] x1, yl1, yq1, ye1, ml1, mq1, al1, aq1;
  logic [15:0] sl0, sq0, sl1, sq1;
  logic busy0, done0, busy1, done1;
  logic [63:0] res0, res1;
  int mode0 = 0, checks = 0, errors = 0, dones0 = 0, dones1 = 0;
  always #5 clk = ~clk;
  assign res0 = {sl0, sq0, ml0, mq0, al0, aq0};
  assign res1 = {sl1, sq1, ml1, mq1, al1, aq1};

  // Core model: mode selects the curve set; returns {lin, quad, exact}
  function automatic logic [23:0] core_fn(int mode, logic [7:0] x);
    int e, l, q, xb, f0, f1;
    e = x; l = x; q = x;
    case (mode)
      1: begin e = x >> 1; l = e + 1; q = e; end
      2: begin e = (x == 127) ? 200 : x; q = (x == 127) ? 0 : x; l = e; end
      3: begin
        e = (x * x) / 256;
        xb = x & 240;
        f0 = (xb * xb) / 256;
        f1 = ((xb + 16) * (xb + 16)) / 256;
        if (f1 > 255) f1 = 255;
        l = f0 + ((f1 - f0) * (x & 15)) / 16;
        q = (x * x + 128) / 256;
      end
      4: begin e = x; l = x + 5; q = x; end
      default: ;
    endcase
    return {l[7:0], q[7:0], e[7:0]};
  endfunction

  function automatic logic [63:0] ref_stats(int mode, int xs, int xe);
    int sl, sq, ml, mq, al, aq, el, eq;
    logic [23:0] v;
    sl = 0; sq = 0; ml = 0; mq = 0; al = 0; aq = 0;
    for (int x = xs; x <= xe; x++) begin
      v = core_fn(mode, x[7:0]);
      el = (int'(v[23:16]) > int'(v[7:0])) ? int'(v[23:16]) - int'(v[7:0]) : int'(v[7:0]) - int'(v[23:16]);
      eq = (int'(v[15:8]) > int'(v[7:0])) ? int'(v[15:8]) - int'(v[7:0]) : int'(v[7:0]) - int'(v[15:8]);
      sl += el; sq += eq;
      if (el > ml) begin ml = el; al = x; end
      if (eq > mq) begin mq = eq; aq = x; end
    end
    return {sl[15:0], sq[15:0], ml[7:0], mq[7:0], al[7:0], aq[7:0]};
  endfunction

  always @(posedge clk) {yl0, yq0, ye0} <= core_fn(mode0, x0);
  always @(posedge clk) {yl1, yq1, ye1} <= core_fn(4, x1);
  always @(negedge clk) begin
    if (done0) dones0++;
    if (done1) dones1++;
  end

  interp_sweep_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .x_out(x0),
    .y_linear(yl0), .y_quadratic(yq0), .y_exact(ye0), .busy(busy0), .done(done0),
    .sum_err_lin(sl0), .sum_err_quad(sq0), .max_err_lin(ml0), .max_err_quad(mq0),
    .argmax_lin(al0), .argmax_quad(aq0));

  interp_sweep_checker #(.X_START(10), .X_END(10), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x_out(x1),
    .y_linear(yl1), .y_quadratic(yq1), .y_exact(ye1), .busy(busy1), .done(done1),
    .sum_err_lin(sl1), .sum_err_quad(sq1), .max_err_lin(ml1), .max_err_quad(mq1),
    .argmax_lin(al1), .argmax_quad(aq1));

  task automatic run_sweep0(output int cycles);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    cycles = 0;
    while (busy0 && cycles < 20000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (x0 !== 8'd0) begin errors++; $display("FAIL reset_x0 got %0d want 0", x0); end
    checks++; if (x1 !== 8'd10) begin errors++; $display("FAIL reset_x1 got %0d want 10", x1); end
    checks++; if ({busy0, done0, busy1, done1} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy0, done0, busy1, done1}); end
    checks++; if (res0 !== 64'd0 || res1 !== 64'd0) begin errors++; $display("FAIL reset_results got %h/%h want 0", res0, res1); end
  endtask

  task automatic test_sweep(string name, int mode, logic [63:0] exp);
    int c, d;
    mode0 = mode;
    d = dones0;
    run_sweep0(c);
    checks++; if (c !== 512) begin errors++; $display("FAIL %s_busy_cycles got %0d want 512", name, c); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", name, done0); end
    @(negedge clk);
    checks++; if (done0 !== 1'b0 || dones0 !== d + 1) begin errors++; $display("FAIL %s_done_pulse got done=%b pulses=%0d want 0/%0d", name, done0, dones0 - d, 1); end
    checks++; if (res0 !== exp) begin errors++; $display("FAIL %s_results got %h want %h", name, res0, exp); end
  endtask

  task automatic test_single_point();
    int c = 0, bad = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    while (busy1 && c < 100) begin
      c++;
      if (x1 !== 8'd10) bad++;
      @(negedge clk);
    end
    checks++; if (c !== 4) begin errors++; $display("FAIL single_busy_cycles got %0d want 4", c); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_x_held got %0d off-point cycles want 0", bad); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", done1); end
    checks++; if (res1 !== {16'd5, 16'd0, 8'd5, 8'd0, 8'd10, 8'd0}) begin errors++; $display("FAIL single_results got %h want %h", res1, {16'd5, 16'd0, 8'd5, 8'd0, 8'd10, 8'd0}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk);
    while (busy1 && c < 100) begin c++; @(negedge clk); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done1); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%b want 0", busy1); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_rearm got busy=%b want 1", busy1); end
    start1 = 1'b0;
    c = 0;
    while (busy1 && c < 100) begin c++; @(negedge clk); end
    @(negedge clk);
  endtask

  task automatic test_real_core();
    int c = 0, d;
    logic [63:0] exp;
    exp = ref_stats(3, 0, 255);
    mode0 = 3;
    d = dones0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    while (busy0 && c < 20000) begin
      c++;
      start0 = (c == 100);
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++; if (c !== 512) begin errors++; $display("FAIL real_busy_cycles got %0d want 512", c); end
    @(negedge clk);
    checks++; if (dones0 !== d + 1) begin errors++; $display("FAIL real_done_count got %0d want 1", dones0 - d); end
    checks++; if (res0 !== exp) begin errors++; $display("FAIL real_results got %h want %h", res0, exp); end
  endtask

  task automatic test_reset_mid();
    int c = 0, d;
    mode0 = 1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    while (x0 !== 8'd100 && c < 2000) begin c++; @(negedge clk); end
    checks++; if (x0 !== 8'd100) begin errors++; $display("FAIL rstmid_reach got x=%0d want 100", x0); end
    rst_n = 1'b0;
    #1;
    checks++; if (x0 !== 8'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL rstmid_state got x=%0d busy=%b done=%b want 0/0/0", x0, busy0, done0); end
    checks++; if (res0 !== 64'd0) begin errors++; $display("FAIL rstmid_results got %h want 0", res0); end
    @(negedge clk) rst_n = 1'b1;
    d = dones0;
    repeat (20) @(negedge clk);
    checks++; if (dones0 !== d || busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got pulses=%0d busy=%b want 0/0", dones0 - d, busy0); end
    test_sweep("rstmid_rerun", 1, {16'd256, 16'd0, 8'd1, 8'd0, 8'd0, 8'd0});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_sweep("identity", 0, 64'd0);
    test_sweep("offset", 1, {16'd256, 16'd0, 8'd1, 8'd0, 8'd0, 8'd0});
    test_sweep("spike", 2, {16'd0, 16'd200, 8'd0, 8'd200, 8'd0, 8'd127});
    test_single_point();
    test_back_to_back();
    test_real_core();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
